down_counter: RTL and testbench

DOWN_COUNTER -- requirements
Module: down_counter

---
 rtl/down_counter.sv | 105 ++++++++++
 tb/tb_down_counter.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/down_counter.sv
// Modulo-N down counter with one-shot/periodic modes, a three-state control FSM,
// a combinational borrow and a registered terminal-count pulse.
module down_counter #(
  parameter int N = 10,
  parameter int M = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         stop,
  input  logic         en,
  input  logic         mode,
  input  logic [M-1:0] load_val,
  output logic [M-1:0] count,
  output logic         busy,
  output logic         bout,
  output logic         done
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [M-1:0] MAX_VAL = M'(N - 1);
  localparam logic [M-1:0] ONE     = M'(1);
  localparam logic [M-1:0] ZERO    = '0;

  state_t       state_q, state_d;
  logic [M-1:0] count_q, count_d;
  logic [M-1:0] reload_q, reload_d;
  logic         mode_q, mode_d;
  logic         done_q, done_d;
  logic [M-1:0] load_clamped;

  assign load_clamped = (load_val > MAX_VAL) ? MAX_VAL : load_val;

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    reload_d = reload_q;
    mode_d   = mode_q;
    done_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        // stop has priority over a simultaneous start
        if (!stop && start) begin
          count_d  = load_clamped;
          reload_d = load_clamped;
          mode_d   = mode;
          state_d  = S_RUN;
        end
      end
      S_RUN: begin
        if (stop) begin
          state_d = S_IDLE;
        end else if (start) begin
          // restart beats a coinciding terminal count, so no done here
          count_d  = load_clamped;
          reload_d = load_clamped;
          mode_d   = mode;
        end else if (en) begin
          if (count_q != ZERO) begin
            count_d = count_q - ONE;
          end else if (mode_q) begin
            count_d = reload_q;
            done_d  = 1'b1;
          end else begin
            state_d = S_DONE;
            done_d  = 1'b1;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      count_q  <= '0;
      reload_q <= '0;
      mode_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      reload_q <= reload_d;
      mode_q   <= mode_d;
      done_q   <= done_d;
    end
  end

  assign count = count_q;
  assign busy  = (state_q == S_RUN);
  assign bout  = (state_q == S_RUN) && (count_q == ZERO);
  assign done  = done_q;

endmodule

// File: tb/tb_down_counter.sv
// Directed bench for down_counter (N=10, M=4): stimulus pushes hand-computed
// expected outputs into a queue; a monitor pops and compares after each edge.
module tb_down_counter;

  logic       clk = 1'b0;
  logic       rst;
  logic       start, stop, en, mode;
  logic [3:0] load_val;
  logic [3:0] count;
  logic       busy, bout, done;

  typedef struct {
    logic [3:0] c;
    logic       b;
    logic       d;
    logic       bo;
    string      nm;
  } exp_t;

  exp_t q[$];
  int   vecs = 0;
  int   errs = 0;
  event sample_now;

  down_counter #(.N(10), .M(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .stop     (stop),
    .en       (en),
    .mode     (mode),
    .load_val (load_val),
    .count    (count),
    .busy     (busy),
    .bout     (bout),
    .done     (done)
  );

  always #5 clk = ~clk;

  task automatic push(input logic [3:0] c, input logic b, input logic d,
                      input logic bo, input string nm);
    exp_t e;
    e.c = c; e.b = b; e.d = d; e.bo = bo; e.nm = nm;
    q.push_back(e);
  endtask

  // Drive inputs on the falling edge; expected values describe the outputs
  // after the following rising edge.
  task automatic step(input logic s, input logic p, input logic e, input logic md,
                      input logic [3:0] lv, input logic [3:0] c, input logic b,
                      input logic d, input logic bo, input string nm);
    @(negedge clk);
    start = s; stop = p; en = e; mode = md; load_val = lv;
    push(c, b, d, bo, nm);
  endtask

  // Monitor: compares one queued expectation per rising edge (or on demand).
  initial begin
    forever begin
      @(posedge clk or sample_now);
      #1;
      if (q.size() != 0) begin
        exp_t e;
        e = q.pop_front();
        vecs++;
        if (count !== e.c || busy !== e.b || done !== e.d || bout !== e.bo) begin
          errs++;
          $display("FAIL %s: got count=%0d busy=%b done=%b bout=%b, expected count=%0d busy=%b done=%b bout=%b",
                   e.nm, count, busy, done, bout, e.c, e.b, e.d, e.bo);
        end
      end
    end
  end

  initial begin
    rst = 1'b0; start = 1'b0; stop = 1'b0; en = 1'b0; mode = 1'b0; load_val = 4'd0;
    #2;
    push(4'd0, 1'b0, 1'b0, 1'b0, "reset_state");
    -> sample_now;
    @(negedge clk);
    rst = 1'b1;

    // one-shot, load 3
    step(1, 0, 1, 0, 4'd3,  4'd3, 1, 0, 0, "os_load");
    step(0, 0, 1, 0, 4'd0,  4'd2, 1, 0, 0, "os_2");
    step(0, 0, 1, 0, 4'd0,  4'd1, 1, 0, 0, "os_1");
    step(0, 0, 1, 0, 4'd0,  4'd0, 1, 0, 1, "os_0");
    step(0, 0, 1, 0, 4'd0,  4'd0, 0, 1, 0, "os_done");
    step(0, 0, 1, 0, 4'd0,  4'd0, 0, 0, 0, "os_idle");
    step(0, 0, 1, 0, 4'd0,  4'd0, 0, 0, 0, "os_idle_hold");

    // periodic, load 2
    step(1, 0, 1, 1, 4'd2,  4'd2, 1, 0, 0, "per_load");
    step(0, 0, 1, 0, 4'd0,  4'd1, 1, 0, 0, "per_1a");
    step(0, 0, 1, 0, 4'd0,  4'd0, 1, 0, 1, "per_0a");
    step(0, 0, 1, 0, 4'd0,  4'd2, 1, 1, 0, "per_reload_a");
    step(0, 0, 1, 0, 4'd0,  4'd1, 1, 0, 0, "per_1b");
    step(0, 0, 1, 0, 4'd0,  4'd0, 1, 0, 1, "per_0b");
    step(0, 0, 1, 0, 4'd0,  4'd2, 1, 1, 0, "per_reload_b");
    step(0, 0, 1, 0, 4'd0,  4'd1, 1, 0, 0, "per_1c");
    step(0, 0, 1, 0, 4'd0,  4'd0, 1, 0, 1, "per_0c");
    step(0, 1, 1, 0, 4'd0,  4'd0, 0, 0, 0, "per_stop_at_tc");

    // clamp, then zero load via restart, then start ignored in DONE
    step(1, 0, 0, 0, 4'd15, 4'd9, 1, 0, 0, "clamp_15");
    step(0, 0, 0, 0, 4'd0,  4'd9, 1, 0, 0, "clamp_hold");
    step(1, 0, 0, 0, 4'd0,  4'd0, 1, 0, 1, "zero_load");
    step(0, 0, 1, 0, 4'd0,  4'd0, 0, 1, 0, "zero_done");
    step(1, 0, 1, 0, 4'd5,  4'd0, 0, 0, 0, "start_in_done");

    // enable gating from 5
    step(1, 0, 0, 0, 4'd5,  4'd5, 1, 0, 0, "en_load5");
    step(0, 0, 1, 0, 4'd0,  4'd4, 1, 0, 0, "en_1");
    step(0, 0, 0, 0, 4'd0,  4'd4, 1, 0, 0, "en_0a");
    step(0, 0, 0, 0, 4'd0,  4'd4, 1, 0, 0, "en_0b");
    step(0, 0, 1, 0, 4'd0,  4'd3, 1, 0, 0, "en_1b");
    step(0, 1, 1, 0, 4'd0,  4'd3, 0, 0, 0, "en_stop");

    // stop versus start, then restart mid-run
    step(1, 0, 0, 0, 4'd6,  4'd6, 1, 0, 0, "ss_load6");
    step(1, 1, 1, 0, 4'd2,  4'd6, 0, 0, 0, "ss_stop_wins");
    step(1, 0, 1, 0, 4'd2,  4'd2, 1, 0, 0, "rs_load2");
    step(0, 0, 1, 0, 4'd0,  4'd1, 1, 0, 0, "rs_1");
    step(1, 0, 1, 1, 4'd7,  4'd7, 1, 0, 0, "rs_restart7");
    step(0, 0, 1, 0, 4'd0,  4'd6, 1, 0, 0, "rs_6");

    // start coinciding with terminal count
    step(1, 0, 1, 0, 4'd1,  4'd1, 1, 0, 0, "tc_load1");
    step(0, 0, 1, 0, 4'd0,  4'd0, 1, 0, 1, "tc_0");
    step(1, 0, 1, 0, 4'd4,  4'd4, 1, 0, 0, "tc_start_wins");
    step(0, 0, 0, 0, 4'd0,  4'd4, 1, 0, 0, "tc_hold");

    // asynchronous reset between edges
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    push(4'd0, 1'b0, 1'b0, 1'b0, "async_rst_now");
    -> sample_now;
    step(0, 0, 1, 0, 4'd0,  4'd0, 0, 0, 0, "rst_held");
    @(negedge clk);
    rst = 1'b1;
    step(0, 0, 1, 0, 4'd0,  4'd0, 0, 0, 0, "post_rst_idle");
    step(1, 0, 1, 0, 4'd2,  4'd2, 1, 0, 0, "post_rst_start");

    @(negedge clk);
    start = 1'b0; en = 1'b0;
    repeat (4) @(posedge clk);
    #2;
    if (q.size() != 0) begin
      errs++;
      $display("FAIL drain: %0d expectations left, required 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
